// File: rtl/tile_match_ram.sv
// rtl/tile_match_ram.sv - tile memory for a pair-matching game, with a command port and a display read port
module tile_match_ram #(
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 16,
    parameter int                ADDR_W    = $clog2(DEPTH),
    parameter logic [DATA_W-1:0] CLEAR_VAL = 8'hFF
) (
    input  logic              gameClk,
    input  logic              rstN,
    input  logic              cmdValid,
    output logic              cmdReady,
    input  logic [1:0]        cmdOp,
    input  logic [ADDR_W-1:0] cmdAddrA,
    input  logic [ADDR_W-1:0] cmdAddrB,
    output logic              rspValid,
    input  logic              rspReady,
    output logic [DATA_W-1:0] rspDataA,
    output logic [DATA_W-1:0] rspDataB,
    output logic              rspMatch,
    input  logic [ADDR_W-1:0] dispAddr,
    output logic [DATA_W-1:0] dispData,
    output logic [ADDR_W-1:0] pairsLeft,
    output logic              boardClear,
    output logic              initDone
);

    localparam logic [1:0]        OP_SWAP    = 2'b01;
    localparam logic [1:0]        OP_MATCH   = 2'b10;
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PAIRS_INIT = ADDR_W'(DEPTH / 2);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_READ,
        S_EXEC,
        S_RESP
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   init_idx;
    logic [1:0]          op;
    logic [ADDR_W-1:0]   addr_a;
    logic [ADDR_W-1:0]   addr_b;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                match_ok;
    logic                wr_en;
    logic [DATA_W-1:0]   wr_a_data;
    logic [DATA_W-1:0]   wr_b_data;

    always_ff @(posedge gameClk or negedge rstN) begin
        if (!rstN) state <= S_INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_INIT:  if (init_idx == LAST_IDX) state_nxt = S_IDLE;
            S_IDLE:  if (cmdValid) state_nxt = S_READ;
            S_READ:  state_nxt = S_EXEC;
            S_EXEC:  state_nxt = S_RESP;
            S_RESP:  if (rspReady) state_nxt = S_IDLE;
            default: state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        cmdReady = (state == S_IDLE);
        rspValid = (state == S_RESP);
        initDone = (state != S_INIT);
    end

    // rspDataA/B hold the values captured in READ, i.e. the pre-op tile contents
    always_comb begin
        match_ok  = (op == OP_MATCH) && (addr_a != addr_b) &&
                    (rspDataA == rspDataB) && (rspDataA != CLEAR_VAL);
        wr_en     = (state == S_EXEC) &&
                    (((op == OP_SWAP) && (addr_a != addr_b)) || match_ok);
        wr_a_data = (op == OP_SWAP) ? rspDataB : CLEAR_VAL;
        wr_b_data = (op == OP_SWAP) ? rspDataA : CLEAR_VAL;
    end

    always_ff @(posedge gameClk or negedge rstN) begin
        if (!rstN) begin
            init_idx  <= '0;
            op        <= '0;
            addr_a    <= '0;
            addr_b    <= '0;
            rspDataA  <= '0;
            rspDataB  <= '0;
            rspMatch  <= 1'b0;
            pairsLeft <= PAIRS_INIT;
        end else begin
            unique case (state)
                S_INIT: begin
                    init_idx <= (init_idx == LAST_IDX) ? '0 : init_idx + 1'b1;
                end
                S_IDLE: begin
                    if (cmdValid) begin
                        op     <= cmdOp;
                        addr_a <= cmdAddrA;
                        addr_b <= cmdAddrB;
                    end
                end
                S_READ: begin
                    rspDataA <= mem[addr_a];
                    rspDataB <= mem[addr_b];
                end
                S_EXEC: begin
                    rspMatch <= match_ok;
                    if (match_ok && (pairsLeft != '0)) pairsLeft <= pairsLeft - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Storage has no reset; the INIT sweep alone defines its contents
    always_ff @(posedge gameClk) begin
        if (state == S_INIT) begin
            mem[init_idx] <= DATA_W'(init_idx >> 1);
        end else if (wr_en) begin
            mem[addr_a] <= wr_a_data;
            mem[addr_b] <= wr_b_data;
        end
    end

    // Non-blocking read of the pre-edge array gives read-before-write on collisions
    always_ff @(posedge gameClk or negedge rstN) begin
        if (!rstN) dispData <= '0;
        else       dispData <= mem[dispAddr];
    end

    assign boardClear = (pairsLeft == '0);

endmodule

// File: tb/tb_tile_match_ram.sv
// tb/tb_tile_match_ram.sv - randomized self-checking bench for tile_match_ram
module tb_tile_match_ram;

    localparam int         DEPTH = 16;
    localparam logic [7:0] CLR   = 8'hFF;

    logic       gameClk = 1'b0;
    logic       rstN    = 1'b0;
    logic       cmdValid = 1'b0;
    logic       cmdReady;
    logic [1:0] cmdOp    = 2'b00;
    logic [3:0] cmdAddrA = '0;
    logic [3:0] cmdAddrB = '0;
    logic       rspValid;
    logic       rspReady = 1'b0;
    logic [7:0] rspDataA;
    logic [7:0] rspDataB;
    logic       rspMatch;
    logic [3:0] dispAddr = '0;
    logic [7:0] dispData;
    logic [3:0] pairsLeft;
    logic       boardClear;
    logic       initDone;

    tile_match_ram dut (
        .gameClk    (gameClk),
        .rstN       (rstN),
        .cmdValid   (cmdValid),
        .cmdReady   (cmdReady),
        .cmdOp      (cmdOp),
        .cmdAddrA   (cmdAddrA),
        .cmdAddrB   (cmdAddrB),
        .rspValid   (rspValid),
        .rspReady   (rspReady),
        .rspDataA   (rspDataA),
        .rspDataB   (rspDataB),
        .rspMatch   (rspMatch),
        .dispAddr   (dispAddr),
        .dispData   (dispData),
        .pairsLeft  (pairsLeft),
        .boardClear (boardClear),
        .initDone   (initDone)
    );

    always #5 gameClk = ~gameClk;

    logic [7:0] board [DEPTH];
    int         pairs;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge gameClk);
        #1;
    endtask

    task automatic reset_and_init();
        rstN     = 1'b0;
        cmdValid = 1'b0;
        rspReady = 1'b0;
        #1;
        check("rst_cmdReady", cmdReady, 0);
        check("rst_rspValid", rspValid, 0);
        check("rst_initDone", initDone, 0);
        tick();
        check("rst_rspData", {rspDataA, rspDataB}, 0);
        check("rst_rspMatch", rspMatch, 0);
        check("rst_dispData", dispData, 0);
        check("rst_pairsLeft", pairsLeft, DEPTH / 2);
        rstN = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) tick();
        check("init_not_ready_yet", cmdReady, 0);
        tick();
        check("init_cmdReady", cmdReady, 1);
        check("init_initDone", initDone, 1);
        for (int i = 0; i < DEPTH; i++) board[i] = 8'(i / 2);
        pairs = DEPTH / 2;
    endtask

    task automatic disp_check(input int a);
        dispAddr = 4'(a);
        tick();
        check($sformatf("disp[%0d]", a), dispData, board[a]);
    endtask

    task automatic run_cmd(input int op, input int a, input int b, input int hold);
        int         waited;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic       exp_m;
        waited = 0;
        while (!cmdReady && waited < 50) begin
            tick();
            waited++;
        end
        check("cmd_ready_wait", cmdReady, 1);
        exp_a = board[a];
        exp_b = board[b];
        exp_m = (op == 2) && (a != b) && (exp_a == exp_b) && (exp_a != CLR);
        cmdValid = 1'b1;
        cmdOp    = 2'(op);
        cmdAddrA = 4'(a);
        cmdAddrB = 4'(b);
        tick();
        cmdValid = 1'b0;
        cmdOp    = 2'($urandom);
        cmdAddrA = 4'($urandom);
        cmdAddrB = 4'($urandom);
        check("accepted_not_ready", cmdReady, 0);
        check("lat_cycle1_rspValid", rspValid, 0);
        tick();
        check("lat_cycle2_rspValid", rspValid, 0);
        tick();
        check("rspValid", rspValid, 1);
        check($sformatf("rspDataA op%0d a%0d", op, a), rspDataA, exp_a);
        check($sformatf("rspDataB op%0d b%0d", op, b), rspDataB, exp_b);
        check($sformatf("rspMatch op%0d %0d/%0d", op, a, b), rspMatch, exp_m);
        if (op == 1 && a != b) begin
            board[a] = exp_b;
            board[b] = exp_a;
        end
        if (exp_m) begin
            board[a] = CLR;
            board[b] = CLR;
            if (pairs > 0) pairs--;
        end
        check("pairsLeft", pairsLeft, pairs);
        check("boardClear", boardClear, pairs == 0);
        for (int h = 0; h < hold; h++) begin
            cmdValid = 1'($urandom_range(0, 1));
            tick();
            check("hold_rspValid", rspValid, 1);
            check("hold_rspData", {rspDataA, rspDataB}, {exp_a, exp_b});
            check("hold_rspMatch", rspMatch, exp_m);
            check("hold_cmdReady", cmdReady, 0);
        end
        cmdValid = 1'b0;
        rspReady = 1'b1;
        tick();
        rspReady = 1'b0;
        check("post_rsp_rspValid", rspValid, 0);
        check("post_rsp_cmdReady", cmdReady, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int a;
        int b;
        reset_and_init();
        disp_check(5);
        check("pairs_after_init", pairsLeft, 8);

        run_cmd(2, 6, 6, 0);
        run_cmd(2, 0, 2, 0);
        run_cmd(1, 0, 3, 0);
        disp_check(0);
        disp_check(3);
        run_cmd(2, 4, 5, 0);
        disp_check(4);
        disp_check(5);
        run_cmd(2, 4, 5, 0);
        run_cmd(0, 7, 9, 5);
        run_cmd(3, 1, 14, 2);

        // reset during EXEC of a swap must abort it and re-init
        run_cmd(0, 1, 1, 0);
        cmdValid = 1'b1;
        cmdOp    = 2'b01;
        cmdAddrA = 4'd1;
        cmdAddrB = 4'd2;
        tick();
        cmdValid = 1'b0;
        tick();
        rstN = 1'b0;
        #1;
        check("midop_rspValid", rspValid, 0);
        check("midop_cmdReady", cmdReady, 0);
        check("midop_initDone", initDone, 0);
        reset_and_init();
        disp_check(0);
        disp_check(1);
        disp_check(2);
        check("midop_pairsLeft", pairsLeft, 8);

        for (int n = 0; n < 80; n++) begin
            a = $urandom_range(0, DEPTH - 1);
            b = ($urandom_range(0, 1) == 1) ? (a ^ 1) : $urandom_range(0, DEPTH - 1);
            run_cmd($urandom_range(0, 3), a, b, $urandom_range(0, 2));
            disp_check($urandom_range(0, DEPTH - 1));
        end

        reset_and_init();
        for (int k = 0; k < DEPTH / 2; k++) run_cmd(2, 2 * k, 2 * k + 1, 0);
        check("all_clear_pairsLeft", pairsLeft, 0);
        check("all_clear_boardClear", boardClear, 1);
        run_cmd(2, 0, 1, 0);
        check("floor_pairsLeft", pairsLeft, 0);
        for (int i = 0; i < DEPTH; i += 5) disp_check(i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
